// File: rtl/gtp_pll0_reset_seq.sv
// PLL0 power-down / reset / lock-qualification sequencer for a GTPE2_COMMON tile.
// Drives PLL0PD and PLL0RESET, filters PLL0LOCK, retries on timeout and publishes pll0_ready.
module gtp_pll0_reset_seq #(
   parameter int INIT_WAIT_CYCLES    = 50,
   parameter int RESET_CYCLES        = 4,
   parameter int LOCK_TIMEOUT_CYCLES = 10000,
   parameter int LOCK_STABLE_CYCLES  = 16,
   parameter int MAX_RETRIES         = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       pll0lock,
   input  logic       pll0refclklost,
   output logic       pll0_pd,
   output logic       pll0_reset,
   output logic       pll0_ready,
   output logic       pll0_fail,
   output logic [3:0] retry_cnt
);

   localparam int MAX_A   = (INIT_WAIT_CYCLES > RESET_CYCLES) ? INIT_WAIT_CYCLES : RESET_CYCLES;
   localparam int MAX_B   = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES
                                                                       : LOCK_STABLE_CYCLES;
   localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(MAX_CNT) + 1;

   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_POWERDOWN,
      S_INIT_WAIT,
      S_RESET,
      S_WAIT_LOCK,
      S_READY,
      S_FAIL
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] stable_q, stable_d;
   logic [3:0]       retry_q, retry_d;
   logic             lock_meta_q, lock_sync_q;
   logic             lost_meta_q, lost_sync_q;
   logic             pd_q, rst_q, rdy_q, fail_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
         lost_meta_q <= 1'b0;
         lost_sync_q <= 1'b0;
      end else begin
         lock_meta_q <= pll0lock;
         lock_sync_q <= lock_meta_q;
         lost_meta_q <= pll0refclklost;
         lost_sync_q <= lost_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_POWERDOWN;
         cnt_q    <= '0;
         stable_q <= '0;
         retry_q  <= '0;
         pd_q     <= 1'b1;
         rst_q    <= 1'b1;
         rdy_q    <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         retry_q  <= retry_d;
         // Outputs are decoded from the next state so they change on the same edge as the state.
         pd_q     <= (state_d == S_POWERDOWN);
         rst_q    <= (state_d == S_POWERDOWN) || (state_d == S_RESET);
         rdy_q    <= (state_d == S_READY);
         fail_q   <= (state_d == S_FAIL);
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      retry_d  = retry_q;
      if (!enable) begin
         state_d  = S_POWERDOWN;
         cnt_d    = '0;
         stable_d = '0;
         retry_d  = '0;
      end else begin
         case (state_q)
            S_POWERDOWN: begin
               state_d = S_INIT_WAIT;
               cnt_d   = '0;
               retry_d = '0;
            end
            S_INIT_WAIT: begin
               if (cnt_q == INIT_LAST) begin
                  state_d = S_RESET;
                  cnt_d   = '0;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            S_RESET: begin
               if (cnt_q == RESET_LAST) begin
                  state_d  = S_WAIT_LOCK;
                  cnt_d    = '0;
                  stable_d = '0;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            S_WAIT_LOCK: begin
               cnt_d    = sat_inc(cnt_q);
               stable_d = lock_sync_q ? sat_inc(stable_q) : '0;
               // Refclk loss aborts without charging a retry; stable lock beats a coincident timeout.
               if (lost_sync_q) begin
                  state_d = S_RESET;
                  cnt_d   = '0;
               end else if (lock_sync_q && (stable_q >= STABLE_LAST)) begin
                  state_d = S_READY;
                  retry_d = '0;
               end else if (cnt_q == TMO_LAST) begin
                  cnt_d = '0;
                  if (retry_q < RETRY_MAX) begin
                     state_d = S_RESET;
                     retry_d = retry_q + 4'd1;
                  end else begin
                     state_d = S_FAIL;
                  end
               end
            end
            S_READY: begin
               if (!lock_sync_q || lost_sync_q) begin
                  state_d = S_RESET;
                  cnt_d   = '0;
               end
            end
            S_FAIL: state_d = S_FAIL;
            default: state_d = S_POWERDOWN;
         endcase
      end
   end

   assign pll0_pd    = pd_q;
   assign pll0_reset = rst_q;
   assign pll0_ready = rdy_q;
   assign pll0_fail  = fail_q;
   assign retry_cnt  = retry_q;

endmodule
